// File: rtl/qed_dispatch_ctrl.sv
// qed_dispatch_ctrl
// Symbolic-QED dispatcher sitting between fetch and decode. Originals pass
// straight through to decode; each accepted original also pushes a remapped
// duplicate into a FIFO. A free formal input (qed_exec_dup) chooses when the
// FIFO head is issued instead. Issue counts, in-flight tracking and a small
// commit FSM feed the property module.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   ifu_valid/instr/ready     original instruction handshake from fetch
//   qed_exec_dup, qed_commit  free formal choices
//   core_valid/instr/ready    issue handshake to decode
//   retire_valid              one instruction retired this cycle
//   sif_commit(_pulsed)       commit level / one-cycle commit pulse
//   sif_state                 commit FSM state (0 PRE, 1 COMMIT, 2 POST)
//   qed_check_valid           drained and balanced, consistency checkable
//   qed_num_orig/dup          issue counters since reset or commit
module qed_dispatch_ctrl #(
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16,
  parameter int FLIGHT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_valid,
  input  logic [31:0]      ifu_instr,
  output logic             ifu_ready,
  input  logic             qed_exec_dup,
  input  logic             qed_commit,
  output logic             core_valid,
  output logic [31:0]      core_instr,
  input  logic             core_ready,
  input  logic             retire_valid,
  output logic             sif_commit,
  output logic             sif_commit_pulsed,
  output logic [1:0]       sif_state,
  output logic             qed_check_valid,
  output logic [CNT_W-1:0] qed_num_orig,
  output logic [CNT_W-1:0] qed_num_dup
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;
  localparam logic [FLIGHT_W-1:0] FL_MAX  = '1;

  typedef enum logic [1:0] {S_PRE = 2'd0, S_COMMIT = 2'd1, S_POST = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [AW:0]         r_head, r_tail;
  logic [31:0]         r_mem [DEPTH];
  logic [CNT_W-1:0]    r_num_orig, r_num_dup;
  logic [FLIGHT_W-1:0] r_flight;
  logic                r_sat;

  logic w_empty, w_full, w_dup_mode, w_in_commit;
  logic w_orig_hs, w_dup_hs, w_issue, w_retire, w_commit_go, w_sat;

  // Duplicate remap. Loads carry imm bits in the rs2 slot and stores carry
  // imm bits in the rd slot, so those register rules are skipped there.
  function automatic logic [31:0] f_dup(input logic [31:0] ins);
    logic [31:0] o;
    logic [11:0] imm;
    logic        is_ld, is_st;
    o     = ins;
    is_ld = (ins[6:0] == 7'b0000011);
    is_st = (ins[6:0] == 7'b0100011);
    imm   = {ins[31:25], ins[11:7]} + 12'd64;
    if (!is_st && |ins[11:7])  o[11] = 1'b1;
    if (|ins[19:15])           o[19] = 1'b1;
    if (!is_ld && |ins[24:20]) o[24] = 1'b1;
    if (is_ld) o[31:20] = ins[31:20] + 12'd64;
    if (is_st) begin
      o[31:25] = imm[11:5];
      o[11:7]  = imm[4:0];
    end
    return o;
  endfunction

  // Pointers carry a wrap bit: equal is empty, MSB-only difference is full.
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[AW] != r_tail[AW]) && (r_head[AW-1:0] == r_tail[AW-1:0]);

  assign w_in_commit = (r_state == S_COMMIT);
  assign w_dup_mode  = qed_exec_dup && !w_empty;

  assign core_instr = w_dup_mode ? r_mem[r_head[AW-1:0]] : ifu_instr;
  assign core_valid = !w_in_commit && (w_dup_mode || (ifu_valid && !w_full));
  assign ifu_ready  = !w_in_commit && !w_dup_mode && core_ready && !w_full;

  assign w_orig_hs   = ifu_valid && ifu_ready;
  assign w_dup_hs    = w_dup_mode && core_ready && !w_in_commit;
  assign w_issue     = w_orig_hs || w_dup_hs;
  assign w_retire    = retire_valid && (r_flight != '0);
  assign w_commit_go = (r_state == S_PRE) && qed_commit && w_empty && (r_flight == '0);

  // Saturation is sticky until reset, including across a commit.
  assign w_sat = r_sat || (r_num_orig == CNT_MAX) || (r_num_dup == CNT_MAX);
  assign qed_check_valid = !w_sat && (r_num_orig == r_num_dup) && w_empty &&
                           (r_flight == '0) && (r_num_orig != '0);
  assign qed_num_orig = r_num_orig;
  assign qed_num_dup  = r_num_dup;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_PRE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PRE:    if (w_commit_go) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_POST;
      S_POST:   w_state_nxt = S_POST;
      default:  w_state_nxt = S_PRE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sif_commit        = (r_state == S_COMMIT) || (r_state == S_POST);
    sif_commit_pulsed = (r_state == S_COMMIT);
    sif_state         = r_state;
  end

  // Queue storage needs no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_orig_hs) r_mem[r_tail[AW-1:0]] <= f_dup(ifu_instr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_num_orig <= '0;
      r_num_dup  <= '0;
      r_flight   <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_orig_hs) r_tail <= r_tail + 1'b1;
      if (w_dup_hs)  r_head <= r_head + 1'b1;

      r_sat <= w_sat;
      if (w_commit_go) begin
        r_num_orig <= '0;
        r_num_dup  <= '0;
      end else begin
        if (w_orig_hs && r_num_orig != CNT_MAX) r_num_orig <= r_num_orig + 1'b1;
        if (w_dup_hs  && r_num_dup  != CNT_MAX) r_num_dup  <= r_num_dup + 1'b1;
      end

      // Issue and retire in the same cycle cancel out.
      case ({w_issue, w_retire})
        2'b10:   if (r_flight != FL_MAX) r_flight <= r_flight + 1'b1;
        2'b01:   r_flight <= r_flight - 1'b1;
        default: r_flight <= r_flight;
      endcase
    end
  end
endmodule

// File: tb/tb_qed_dispatch_ctrl.sv
module tb_qed_dispatch_ctrl;
  localparam int DEPTH = 16, CNT_W = 16, FLIGHT_W = 4;
  localparam logic [31:0] ADD = 32'h002081B3, ADD_D = 32'h012889B3;
  localparam logic [31:0] LW  = 32'h00402283, LW_D  = 32'h04402A83;
  localparam logic [31:0] SW  = 32'h00502223, SW_D  = 32'h05502223;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ifu_valid, ifu_ready, qed_exec_dup, qed_commit;
  logic core_valid, core_ready, retire_valid;
  logic sif_commit, sif_commit_pulsed, qed_check_valid;
  logic [31:0] ifu_instr, core_instr;
  logic [1:0] sif_state;
  logic [CNT_W-1:0] qed_num_orig, qed_num_dup;

  qed_dispatch_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .FLIGHT_W(FLIGHT_W)) dut (
    .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_instr(ifu_instr),
    .ifu_ready(ifu_ready), .qed_exec_dup(qed_exec_dup), .qed_commit(qed_commit),
    .core_valid(core_valid), .core_instr(core_instr), .core_ready(core_ready),
    .retire_valid(retire_valid), .sif_commit(sif_commit),
    .sif_commit_pulsed(sif_commit_pulsed), .sif_state(sif_state),
    .qed_check_valid(qed_check_valid), .qed_num_orig(qed_num_orig),
    .qed_num_dup(qed_num_dup));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference duplicate transform, from field arithmetic on the encoding.
  function automatic logic [31:0] xf(input logic [31:0] i);
    int unsigned op, rd, rs1, rs2, imm;
    logic [31:0] o;
    op = i % 128; rd = (i >> 7) % 32; rs1 = (i >> 15) % 32; rs2 = (i >> 20) % 32;
    o = i;
    if (op == 3) begin
      imm = ((i >> 20) + 64) % 4096;
      o = (i % (1 << 20)) + (imm << 20);
      if (rd != 0) o = o | (32'd1 << 11);
      if (rs1 != 0) o = o | (32'd1 << 19);
    end else if (op == 35) begin
      imm = (((i >> 25) * 32 + rd) + 64) % 4096;
      o = (i & 32'h01FFF07F) | ((imm / 32) << 25) | ((imm % 32) << 7);
      if (rs1 != 0) o = o | (32'd1 << 19);
      if (rs2 != 0) o = o | (32'd1 << 24);
    end else begin
      if (rd != 0) o = o | (32'd1 << 11);
      if (rs1 != 0) o = o | (32'd1 << 19);
      if (rs2 != 0) o = o | (32'd1 << 24);
    end
    return o;
  endfunction

  // Behavioural model: a queue of duplicates, plain integer counters, phase 0/1/2.
  logic [31:0] mq[$];
  int m_no, m_nd, m_fl, m_st;

  task automatic m_check();
    bit dupm, inc, full, ecv, eir;
    if (!rst) return;
    dupm = qed_exec_dup && mq.size() > 0;
    inc  = (m_st == 1);
    full = (mq.size() == DEPTH);
    ecv  = !inc && (dupm || (ifu_valid && !full));
    eir  = !inc && !dupm && core_ready && !full;
    chk("m_core_valid", core_valid, ecv);
    chk("m_ifu_ready", ifu_ready, eir);
    if (ecv) chk("m_core_instr", core_instr, dupm ? mq[0] : ifu_instr);
    chk("m_check_valid", qed_check_valid,
        m_no == m_nd && mq.size() == 0 && m_fl == 0 && m_no != 0);
    chk("m_num_orig", qed_num_orig, m_no);
    chk("m_num_dup", qed_num_dup, m_nd);
    chk("m_state", sif_state, m_st);
    chk("m_commit", sif_commit, m_st != 0);
    chk("m_pulsed", sif_commit_pulsed, m_st == 1);
  endtask

  task automatic m_edge();
    bit dupm, inc, full, ohs, dhs, ret, go;
    if (!rst) begin
      mq.delete(); m_no = 0; m_nd = 0; m_fl = 0; m_st = 0;
      return;
    end
    dupm = qed_exec_dup && mq.size() > 0;
    inc  = (m_st == 1);
    full = (mq.size() == DEPTH);
    ohs  = ifu_valid && !inc && !dupm && core_ready && !full;
    dhs  = dupm && core_ready && !inc;
    ret  = retire_valid && m_fl > 0;
    go   = m_st == 0 && qed_commit && mq.size() == 0 && m_fl == 0;
    if (ohs) mq.push_back(xf(ifu_instr));
    if (dhs) void'(mq.pop_front());
    if ((ohs || dhs) && !ret) m_fl = (m_fl < 15) ? m_fl + 1 : 15;
    else if (ret && !(ohs || dhs)) m_fl--;
    if (go) begin m_no = 0; m_nd = 0; end
    else begin
      if (ohs && m_no < 65535) m_no++;
      if (dhs && m_nd < 65535) m_nd++;
    end
    m_st = (m_st == 0) ? (go ? 1 : 0) : 2;
  endtask

  task automatic apply(input bit iv, input logic [31:0] ins, input bit dup,
                       input bit cmt, input bit rdy, input bit ret, input bit rstn);
    rst = rstn; ifu_valid = iv; ifu_instr = ins; qed_exec_dup = dup;
    qed_commit = cmt; core_ready = rdy; retire_valid = ret;
    #3;
  endtask

  task automatic tick();
    m_check();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] ops [5] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 4)];
    return r;
  endfunction

  typedef struct {
    bit iv; logic [31:0] ins; bit dup, rdy, ret;
    bit e_cv; logic [31:0] e_ci; bit e_ir, e_chk; int e_no, e_nd;
  } vec_t;
  vec_t tbl[13];
  logic [31:0] pushed[16];

  initial begin
    tbl[0]  = '{1, ADD, 0, 1, 0,  1, ADD,   1, 0, 0, 0};
    tbl[1]  = '{0, 0,   1, 1, 0,  1, ADD_D, 0, 0, 1, 0};
    tbl[2]  = '{0, 0,   0, 0, 1,  0, 0,     0, 0, 1, 1};
    tbl[3]  = '{0, 0,   0, 0, 1,  0, 0,     0, 0, 1, 1};
    tbl[4]  = '{0, 0,   0, 0, 0,  0, 0,     0, 1, 1, 1};
    tbl[5]  = '{1, LW,  0, 1, 0,  1, LW,    1, 1, 1, 1};
    tbl[6]  = '{0, 0,   1, 1, 0,  1, LW_D,  0, 0, 2, 1};
    tbl[7]  = '{1, SW,  0, 1, 1,  1, SW,    1, 0, 2, 2};
    tbl[8]  = '{0, 0,   1, 0, 0,  1, SW_D,  0, 0, 3, 2};
    tbl[9]  = '{0, 0,   1, 1, 1,  1, SW_D,  0, 0, 3, 2};
    tbl[10] = '{0, 0,   0, 0, 1,  0, 0,     0, 0, 3, 3};
    tbl[11] = '{0, 0,   0, 0, 1,  0, 0,     0, 0, 3, 3};
    tbl[12] = '{0, 0,   0, 0, 0,  0, 0,     0, 1, 3, 3};

    // Reset state
    apply(0, 0, 0, 0, 0, 0, 0); tick();
    apply(1, ADD, 0, 0, 0, 0, 1);
    chk("rst_state", sif_state, 0);
    chk("rst_orig", qed_num_orig, 0);
    chk("rst_dup", qed_num_dup, 0);
    chk("rst_chk", qed_check_valid, 0);
    chk("rst_commit", sif_commit, 0);
    chk("rst_pulse", sif_commit_pulsed, 0);
    chk("rst_cv", core_valid, 1);
    tick();

    // Directed vectors: add / lw / sw originals and their duplicates
    foreach (tbl[k]) begin
      apply(tbl[k].iv, tbl[k].ins, tbl[k].dup, 0, tbl[k].rdy, tbl[k].ret, 1);
      chk($sformatf("v%0d_cv", k), core_valid, tbl[k].e_cv);
      if (tbl[k].e_cv) chk($sformatf("v%0d_ci", k), core_instr, tbl[k].e_ci);
      chk($sformatf("v%0d_ir", k), ifu_ready, tbl[k].e_ir);
      chk($sformatf("v%0d_chk", k), qed_check_valid, tbl[k].e_chk);
      chk($sformatf("v%0d_no", k), qed_num_orig, tbl[k].e_no);
      chk($sformatf("v%0d_nd", k), qed_num_dup, tbl[k].e_nd);
      tick();
    end

    // Fill the queue, then drain it in FIFO order
    apply(0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      pushed[i] = {12'(i + 1), 5'(i + 1), 3'b000, 5'(i + 1), 7'h13};
      apply(1, pushed[i], 0, 0, 1, 0, 1);
      chk("fill_ir", ifu_ready, 1);
      tick();
    end
    apply(1, 32'h13, 0, 0, 1, 0, 1);
    chk("full_ir", ifu_ready, 0);
    chk("full_cv", core_valid, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      apply(1, 32'h13, 1, 0, 1, 0, 1);
      chk("drain_ci", core_instr, xf(pushed[i]));
      chk("drain_ir", ifu_ready, 0);
      tick();
    end
    apply(0, 0, 0, 0, 1, 0, 1);
    chk("drained_ir", ifu_ready, 1);
    tick();

    // 32 issues saturate in-flight at 15: 14 retires leave one outstanding
    for (int i = 0; i < 14; i++) begin apply(0, 0, 0, 0, 0, 1, 1); tick(); end
    apply(0, 0, 0, 1, 0, 0, 1);
    chk("fl_sat_chk", qed_check_valid, 0);
    tick();
    apply(0, 0, 0, 0, 0, 1, 1);
    chk("commit_blocked", sif_commit_pulsed, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("bal_chk", qed_check_valid, 1);
    chk("bal_no", qed_num_orig, 16);
    tick();

    // Commit pulse
    apply(0, 0, 0, 1, 0, 0, 1); tick();
    apply(1, 32'h13, 0, 0, 1, 0, 1);
    chk("cm_pulse", sif_commit_pulsed, 1);
    chk("cm_level", sif_commit, 1);
    chk("cm_no", qed_num_orig, 0);
    chk("cm_nd", qed_num_dup, 0);
    chk("cm_cv", core_valid, 0);
    chk("cm_ir", ifu_ready, 0);
    tick();
    apply(0, 0, 0, 1, 0, 0, 1);
    chk("cm_pulse_off", sif_commit_pulsed, 0);
    chk("cm_level2", sif_commit, 1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("cm_second", sif_commit_pulsed, 0);
    chk("cm_post", sif_state, 2);
    tick();

    // Reset mid-operation: 3 queued, 2 in flight
    apply(0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin apply(1, rand_instr(), 0, 0, 1, 0, 1); tick(); end
    apply(0, 0, 0, 0, 0, 1, 1); tick();
    apply(0, 0, 1, 0, 1, 0, 0); tick();
    apply(1, ADD, 1, 0, 0, 0, 1);
    chk("mr_ci", core_instr, ADD);
    chk("mr_state", sif_state, 0);
    chk("mr_no", qed_num_orig, 0);
    tick();
    apply(0, 0, 0, 1, 0, 0, 1); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("mr_flight0", sif_commit_pulsed, 1);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      apply($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 249) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/qed_dispatch_ctrl.md
# qed_dispatch_ctrl

Symbolic-QED instruction dispatcher between the fetch unit and the core decode stage of the formal harness. It accepts original instructions from fetch and, under control of a free formal input, interleaves QED duplicates (registers x1–x15 remapped to x17–x31, memory words 0–15 remapped to 16–31) drawn from an internal queue. It counts original and duplicate issues, tracks in-flight instructions, and drives the commit and consistency-check signals (`sif_commit`, `sif_commit_pulsed`, `qed_check_valid`) that the property module samples.

## Interface
- DEPTH, 16, duplicate-queue entries; power of two, at least 2
- CNT_W, 16, width of the issue counters
- FLIGHT_W, 4, width of the in-flight counter

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- ifu_valid  in  1  original instruction offered by fetch
- ifu_instr  in  32  original RV32I instruction
- ifu_ready  out  1  original is accepted this cycle
- qed_exec_dup  in  1  free formal choice; request a duplicate issue
- qed_commit  in  1  free formal choice; request the commit point
- core_valid  out  1  `core_instr` is valid
- core_instr  out  32  instruction presented to decode
- core_ready  in  1  decode accepts `core_instr`
- retire_valid  in  1  one instruction retired this cycle
- sif_commit  out  1  level signal; high from the commit point onward
- sif_commit_pulsed  out  1  one-cycle pulse at the commit point
- qed_check_valid  out  1  drained and balanced; consistency may be checked
- qed_num_orig  out  CNT_W  originals issued since the last reset or commit
- qed_num_dup  out  CNT_W  duplicates issued since the last reset or commit

## Operation
- Duplicate transform, applied at enqueue:
  - Set bit 4 of rd [11], rs1 [19] and rs2 [24] when the field is nonzero.
  - Loads (opcode 0000011): add 64 to imm[11:0] (bits [31:20]), modulo 2^12.
  - Stores (opcode 0100011): add 64 to the split immediate {[31:25],[11:7]}, modulo 2^12. The rd rule does not apply to stores.
  - All other opcodes: register-field rule only.
- Issue select, evaluated every cycle:
  - Duplicate mode when `qed_exec_dup` is high and the queue is non-empty. `core_instr` is the queue head; `ifu_ready` = 0.
  - Otherwise original mode. `core_instr` = `ifu_instr`, `core_valid` = `ifu_valid`, and `ifu_ready` = `core_ready` AND queue not full.
  - When the queue is full and `qed_exec_dup` is low: `core_valid` = 0 and `ifu_ready` = 0.
- On an original handshake: enqueue the transformed copy and increment `qed_num_orig`.
- On a duplicate handshake: dequeue the head and increment `qed_num_dup`.
- Queue pointers are log2(DEPTH)+1 bits wide (wrap bit).
  - Empty: head == tail.
  - Full: pointers differ only in the MSB.
- In-flight counter:
  - +1 per issue handshake, −1 per `retire_valid`; both in the same cycle leaves it unchanged.
  - Saturates at 2^FLIGHT_W−1.
  - `retire_valid` while the count is 0 is ignored.
- `qed_check_valid` = (`qed_num_orig` == `qed_num_dup`) AND queue empty AND in-flight == 0 AND `qed_num_orig` != 0. It is combinational from registered state.
- FSM:
  - PRE (`sif_state`=0) → COMMIT when `qed_commit` is high and the queue is empty and in-flight == 0.
  - COMMIT (1) → POST after one cycle.
  - POST (2) is absorbing until reset.
- `sif_commit_pulsed` = 1 only in COMMIT.
- `sif_commit` = 1 in COMMIT and POST.
- Entering COMMIT clears both issue counters. No issue handshake is permitted in COMMIT (`core_valid` = 0).
- Issue counters saturate at 2^CNT_W−1. Once either counter saturates, `qed_check_valid` is forced to 0 until reset.

## Timing
- Reset (`rst` = 0 at a rising edge) clears pointers, counters, in-flight and FSM. Outputs after reset:
  - `sif_state` = PRE; `sif_commit` = 0; `sif_commit_pulsed` = 0; `qed_check_valid` = 0.
  - `qed_num_orig` = 0; `qed_num_dup` = 0.
  - `core_valid` = `ifu_valid`, since the queue is empty.
- Reset asserted mid-operation discards queue contents the same cycle; no partial state survives.
- Issue path is zero-latency combinational fetch → decode; the queue adds no bubble.
- A duplicate may issue the cycle after its original was enqueued, not the same cycle.
- Counter, queue and FSM updates take effect at the edge following the handshake.
- `qed_check_valid` reflects the post-edge state.
- `qed_commit` is ignored outside PRE and whenever its drain condition fails. It is not latched.

## Test plan
- Reset → `sif_state`=0, counters 0, `qed_check_valid`=0, `sif_commit`=0.
- Issue `add x3,x1,x2` (0x002081B3) as an original, then a duplicate, then retire both → duplicate `core_instr`=0x012889B3; counters 1/1; `qed_check_valid`=1.
- Original `lw x5,4(x0)` (0x00402283) → duplicate 0x04402A83; original `sw x5,4(x0)` (0x00502223) → duplicate 0x05502223.
- Push 16 originals with `qed_exec_dup`=0 → `ifu_ready`=0 and `core_valid`=0 from the cycle after the 16th; assert `qed_exec_dup` → 16 duplicates drain in FIFO order and `ifu_ready` returns to 1.
- With the queue empty and in-flight 0, pulse `qed_commit` → `sif_commit_pulsed` high exactly one cycle, `sif_commit` stays 1, counters reset to 0; a second `qed_commit` has no effect.
- Assert reset with 3 entries queued and in-flight 2 → the next cycle shows empty queue, in-flight 0, FSM PRE.
